i2c_txn_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one byte-level I2C master engine (`i2c_fsm` class) between `N_REQ` requesters. It latches one requester's transaction (7-bit address, R/W, write byte), issues it to the engine with a single start pulse, and waits for completion or timeout. It then returns the read byte and error status to that requester only. It sits between client logic (sensor pollers, codec setup) and the I2C engine, and exports a 4-bit state code for seven-segment debug display.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_txn_arbiter_if.sv | 47 ++++
 rtl/rr_pick.sv | 31 +++
 rtl/i2c_txn_arbiter.sv | 165 ++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
// The state encoding doubles as the 4-bit debug code shown on the display.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int STATE_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_ISSUE   = 4'd1,
        ST_WAIT    = 4'd2,
        ST_RESPOND = 4'd3
    } arb_state_t;

    // Next requester index in round-robin order, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the arbiter.
// The master modport is the arbiter's view; slave is the clients plus engine.
// N_REQ must match the N_REQ of the arbiter the bundle is connected to.
interface i2c_txn_arbiter_if #(
    parameter int N_REQ = 2
);
    import i2c_pkg::*;

    // Requester side
    logic [N_REQ-1:0]            req_valid;
    logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
    logic [N_REQ-1:0]            req_rw;
    logic [I2C_DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [I2C_DATA_W-1:0]       rsp_data;
    logic                        rsp_err;

    // Engine side
    logic                        m_start;
    logic [I2C_ADDR_W-1:0]       m_addr;
    logic                        m_rw;
    logic [I2C_DATA_W-1:0]       m_wdata;
    logic                        m_done;
    logic [I2C_DATA_W-1:0]       m_rdata;
    logic                        m_nack;

    // Debug display
    logic [STATE_W-1:0]          state_info;

    modport master (
        input  req_valid, req_addr, req_rw, req_wdata,
        input  m_done, m_rdata, m_nack,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output m_start, m_addr, m_rw, m_wdata,
        output state_info
    );

    modport slave (
        output req_valid, req_addr, req_rw, req_wdata,
        output m_done, m_rdata, m_nack,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  m_start, m_addr, m_rw, m_wdata,
        input  state_info
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans the request vector starting one
// past the last owner, wrapping, and reports the first requester found.
module rr_pick
    import i2c_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    // Walk N_REQ candidates from last+1; first asserted request wins.
    always_comb begin
        int cand;
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        winner = '0;
        any    = 1'b0;
        cand   = int'(last);
        for (int i = 0; i < N_REQ; i++) begin
            cand = rr_next(cand, N_REQ);
            if (!any && req[IDX_W'(cand)]) begin
                winner = IDX_W'(cand);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one byte-level I2C engine between N_REQ requesters. One transaction
// is latched, issued with a single start pulse, and completed by engine done
// or by timeout; the result goes back to the owning requester only.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_txn_arbiter_if.master    bus
);

    localparam int               IDX_W       = $clog2(N_REQ);
    localparam int               CNT_W       = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    // Starting with the highest index as last owner makes requester 0 win first.
    localparam logic [IDX_W-1:0] OWNER_RESET = IDX_W'(N_REQ - 1);

    arb_state_t            state_q;
    arb_state_t            state_d;

    logic [IDX_W-1:0]      win;
    logic                  any_valid;
    logic [IDX_W-1:0]      owner_q;
    logic [IDX_W-1:0]      last_owner_q;

    logic [I2C_ADDR_W-1:0] sel_addr;
    logic                  sel_rw;
    logic [I2C_DATA_W-1:0] sel_wdata;

    logic [I2C_ADDR_W-1:0] addr_q;
    logic                  rw_q;
    logic [I2C_DATA_W-1:0] wdata_q;
    logic [I2C_DATA_W-1:0] rdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  expired;

    logic [N_REQ-1:0]      ready_d;
    logic [N_REQ-1:0]      rsp_valid_d;
    logic                  start_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req_valid),
        .last   (last_owner_q),
        .winner (win),
        .any    (any_valid)
    );

    assign expired = (cnt_q == CNT_LAST);

    // Extract the winning requester's fields from the packed request buses.
    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                sel_addr  = bus.req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                sel_rw    = bus.req_rw[i];
                sel_wdata = bus.req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking (<=) for every flop so all registers sample pre-edge values.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_valid) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT:    if (bus.m_done || expired) state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath: latch request, run timeout counter, capture result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= '0;
            last_owner_q <= OWNER_RESET;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        owner_q <= win;
                        addr_q  <= sel_addr;
                        rw_q    <= sel_rw;
                        wdata_q <= sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= '0;
                end
                ST_WAIT: begin
                    // Done takes priority over a timeout expiring in the same cycle.
                    if (bus.m_done) begin
                        rdata_q <= bus.m_rdata;
                        err_q   <= bus.m_nack;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        // Only reached below CNT_LAST, so the counter can never wrap.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    last_owner_q <= owner_q;
                end
                default: ;
            endcase
        end
    end

    // Output decode: pulses depend only on registered state and owner.
    always_comb begin
        ready_d     = '0;
        rsp_valid_d = '0;
        start_d     = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                ready_d[owner_q] = 1'b1;
                start_d          = 1'b1;
            end
            ST_RESPOND: begin
                rsp_valid_d[owner_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = ready_d;
    assign bus.rsp_valid  = rsp_valid_d;
    assign bus.rsp_data   = rdata_q;
    assign bus.rsp_err    = err_q;
    assign bus.m_start    = start_d;
    assign bus.m_addr     = addr_q;
    assign bus.m_rw       = rw_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.state_info = state_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter. Two instances: dut_a (TIMEOUT=64)
// for normal traffic, dut_t (TIMEOUT=16) for timeout behaviour. The sequence
// pushes hand-computed expectations; negedge monitors pop and compare.
module tb_i2c_txn_arbiter;
    import i2c_pkg::*;

    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_txn_arbiter_if #(.N_REQ(NR)) bus_a ();
    i2c_txn_arbiter_if #(.N_REQ(NR)) bus_t ();

    i2c_txn_arbiter #(.N_REQ(NR), .TIMEOUT(64)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    i2c_txn_arbiter #(.N_REQ(NR), .TIMEOUT(16)) dut_t (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_t)
    );

    typedef struct {
        int         owner;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         cyc;
    } issue_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
        logic       err;
        int         cyc;
    } rsp_t;

    issue_t iss_qa[$];
    issue_t iss_qt[$];
    rsp_t   rsp_qa[$];
    rsp_t   rsp_qt[$];

    int n_checks = 0;
    int n_errors = 0;

    // Engine model settings per instance (0 = a, 1 = t); delay < 0 means silent.
    int         eng_delay [2];
    logic [7:0] eng_rdata [2];
    logic       eng_nack  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int owner, input logic [6:0] addr, input logic rw,
                        input logic [7:0] wdata, input int icyc, input bit with_rsp,
                        input logic [7:0] data, input logic err, input int rcyc);
        issue_t ie;
        rsp_t   re;
        ie = '{owner: owner, addr: addr, rw: rw, wdata: wdata, cyc: icyc};
        re = '{owner: owner, data: data, err: err, cyc: rcyc};
        if (d == 0) begin
            iss_qa.push_back(ie);
            if (with_rsp) rsp_qa.push_back(re);
        end else begin
            iss_qt.push_back(ie);
            if (with_rsp) rsp_qt.push_back(re);
        end
    endtask

    task automatic mon_issue(input int d, input string tag, input logic start,
                             input logic [NR-1:0] ready, input logic [6:0] addr,
                             input logic rw, input logic [7:0] wdata);
        issue_t e;
        int     sz;
        if (ready != '0) check({tag, "_ready_with_start"}, 32'(start), 32'd1);
        if (!start) return;
        sz = (d == 0) ? iss_qa.size() : iss_qt.size();
        if (sz == 0) begin
            check({tag, "_unexpected_start"}, 32'(start), 32'd0);
            return;
        end
        if (d == 0) e = iss_qa.pop_front();
        else        e = iss_qt.pop_front();
        check({tag, "_issue_ready_onehot"}, 32'(ready), 32'(1 << e.owner));
        check({tag, "_issue_addr"},  32'(addr),  32'(e.addr));
        check({tag, "_issue_rw"},    32'(rw),    32'(e.rw));
        check({tag, "_issue_wdata"}, 32'(wdata), 32'(e.wdata));
        check({tag, "_issue_cycle"}, 32'(cyc),   32'(e.cyc));
    endtask

    task automatic mon_rsp(input int d, input string tag, input logic [NR-1:0] valid,
                           input logic [7:0] data, input logic err);
        rsp_t e;
        int   sz;
        if (valid == '0) return;
        sz = (d == 0) ? rsp_qa.size() : rsp_qt.size();
        if (sz == 0) begin
            check({tag, "_unexpected_rsp"}, 32'(valid), 32'd0);
            return;
        end
        if (d == 0) e = rsp_qa.pop_front();
        else        e = rsp_qt.pop_front();
        check({tag, "_rsp_valid_onehot"}, 32'(valid), 32'(1 << e.owner));
        check({tag, "_rsp_data"},  32'(data), 32'(e.data));
        check({tag, "_rsp_err"},   32'(err),  32'(e.err));
        check({tag, "_rsp_cycle"}, 32'(cyc),  32'(e.cyc));
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon_issue(0, "a", bus_a.m_start, bus_a.req_ready, bus_a.m_addr, bus_a.m_rw, bus_a.m_wdata);
        mon_rsp(0, "a", bus_a.rsp_valid, bus_a.rsp_data, bus_a.rsp_err);
    end

    always @(negedge clk) begin
        mon_issue(1, "t", bus_t.m_start, bus_t.req_ready, bus_t.m_addr, bus_t.m_rw, bus_t.m_wdata);
        mon_rsp(1, "t", bus_t.rsp_valid, bus_t.rsp_data, bus_t.rsp_err);
    end

    // Engine model for dut_a: done pulse 'delay' cycles after the start cycle.
    initial begin
        int dl;
        bus_a.m_done = 1'b0; bus_a.m_rdata = '0; bus_a.m_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_a.m_start && eng_delay[0] > 0) begin
                dl = eng_delay[0];
                repeat (dl) @(posedge clk);
                #1;
                bus_a.m_done = 1'b1; bus_a.m_rdata = eng_rdata[0]; bus_a.m_nack = eng_nack[0];
                @(posedge clk);
                #1;
                bus_a.m_done = 1'b0; bus_a.m_nack = 1'b0;
            end
        end
    end

    // Engine model for dut_t.
    initial begin
        int dl;
        bus_t.m_done = 1'b0; bus_t.m_rdata = '0; bus_t.m_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_t.m_start && eng_delay[1] > 0) begin
                dl = eng_delay[1];
                repeat (dl) @(posedge clk);
                #1;
                bus_t.m_done = 1'b1; bus_t.m_rdata = eng_rdata[1]; bus_t.m_nack = eng_nack[1];
                @(posedge clk);
                #1;
                bus_t.m_done = 1'b0; bus_t.m_nack = 1'b0;
            end
        end
    end

    task automatic set_req(input int d, input int i, input logic [6:0] addr, input logic rw,
                           input logic [7:0] wdata);
        if (d == 0) begin
            bus_a.req_addr[i*7 +: 7] = addr; bus_a.req_rw[i] = rw;
            bus_a.req_wdata[i*8 +: 8] = wdata; bus_a.req_valid[i] = 1'b1;
        end else begin
            bus_t.req_addr[i*7 +: 7] = addr; bus_t.req_rw[i] = rw;
            bus_t.req_wdata[i*8 +: 8] = wdata; bus_t.req_valid[i] = 1'b1;
        end
    endtask

    task automatic drop_req(input int d, input int i);
        if (d == 0) bus_a.req_valid[i] = 1'b0;
        else        bus_t.req_valid[i] = 1'b0;
    endtask

    task automatic wait_ready(input int d, input int i, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = (d == 0) ? bus_a.req_ready[i] : bus_t.req_ready[i];
        end
        if (!seen) check({tag, "_ready_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int d, input string tag);
        if (d == 0) begin
            check({tag, "_req_ready"},  32'(bus_a.req_ready),  32'd0);
            check({tag, "_rsp_valid"},  32'(bus_a.rsp_valid),  32'd0);
            check({tag, "_rsp_data"},   32'(bus_a.rsp_data),   32'd0);
            check({tag, "_rsp_err"},    32'(bus_a.rsp_err),    32'd0);
            check({tag, "_m_start"},    32'(bus_a.m_start),    32'd0);
            check({tag, "_m_addr"},     32'(bus_a.m_addr),     32'd0);
            check({tag, "_m_rw"},       32'(bus_a.m_rw),       32'd0);
            check({tag, "_m_wdata"},    32'(bus_a.m_wdata),    32'd0);
            check({tag, "_state_info"}, 32'(bus_a.state_info), 32'd0);
        end else begin
            check({tag, "_req_ready"},  32'(bus_t.req_ready),  32'd0);
            check({tag, "_m_start"},    32'(bus_t.m_start),    32'd0);
            check({tag, "_state_info"}, 32'(bus_t.state_info), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        bus_a.req_valid = '0; bus_a.req_addr = '0; bus_a.req_rw = '0; bus_a.req_wdata = '0;
        bus_t.req_valid = '0; bus_t.req_addr = '0; bus_t.req_rw = '0; bus_t.req_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            eng_delay[i] = 1; eng_rdata[i] = '0; eng_nack[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #2;
        check_zero(0, "reset_a");
        check_zero(1, "reset_t");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write from requester 0; engine done 20 cycles after start.
        eng_delay[0] = 20; eng_rdata[0] = 8'h77; eng_nack[0] = 1'b0;
        t = cyc;
        set_req(0, 0, 7'h48, 1'b0, 8'hA5);
        push(0, 0, 7'h48, 1'b0, 8'hA5, t + 1, 1'b1, 8'h77, 1'b0, t + 22);
        wait_ready(0, 0, "wr0");
        @(posedge clk); #1 drop_req(0, 0);
        wait_until(t + 25);

        // Read from requester 1 returning 0x3C.
        eng_delay[0] = 3; eng_rdata[0] = 8'h3C; eng_nack[0] = 1'b0;
        t = cyc;
        set_req(0, 1, 7'h1D, 1'b1, 8'h00);
        push(0, 1, 7'h1D, 1'b1, 8'h00, t + 1, 1'b1, 8'h3C, 1'b0, t + 5);
        wait_ready(0, 1, "rd1");
        @(posedge clk); #1 drop_req(0, 1);
        wait_until(t + 8);

        // Both held valid for four transactions: grants 0,1,0,1, period 8.
        eng_delay[0] = 5; eng_rdata[0] = 8'h99; eng_nack[0] = 1'b0;
        t = cyc;
        set_req(0, 0, 7'h10, 1'b0, 8'h11);
        set_req(0, 1, 7'h20, 1'b1, 8'h22);
        push(0, 0, 7'h10, 1'b0, 8'h11, t + 1,  1'b1, 8'h99, 1'b0, t + 7);
        push(0, 1, 7'h20, 1'b1, 8'h22, t + 9,  1'b1, 8'h99, 1'b0, t + 15);
        push(0, 0, 7'h10, 1'b0, 8'h11, t + 17, 1'b1, 8'h99, 1'b0, t + 23);
        push(0, 1, 7'h20, 1'b1, 8'h22, t + 25, 1'b1, 8'h99, 1'b0, t + 31);
        for (int g = 0; g < 4; g++) wait_ready(0, g % 2, "rr");
        @(posedge clk); #1 drop_req(0, 0); drop_req(0, 1);
        wait_until(t + 34);

        // Engine NACK on a normal completion.
        eng_delay[0] = 2; eng_rdata[0] = 8'hE1; eng_nack[0] = 1'b1;
        t = cyc;
        set_req(0, 0, 7'h2A, 1'b0, 8'h3F);
        push(0, 0, 7'h2A, 1'b0, 8'h3F, t + 1, 1'b1, 8'hE1, 1'b1, t + 4);
        wait_ready(0, 0, "nack");
        @(posedge clk); #1 drop_req(0, 0);
        wait_until(t + 7);

        // Silent engine, TIMEOUT=16: response 16 cycles after WAIT entry.
        eng_delay[1] = -1;
        t = cyc;
        set_req(1, 1, 7'h50, 1'b1, 8'h00);
        push(1, 1, 7'h50, 1'b1, 8'h00, t + 1, 1'b1, 8'h00, 1'b1, t + 18);
        wait_ready(1, 1, "tmo");
        @(posedge clk); #1 drop_req(1, 1);
        wait_until(t + 21);

        // Next request after a timeout completes normally.
        eng_delay[1] = 4; eng_rdata[1] = 8'h42; eng_nack[1] = 1'b0;
        t = cyc;
        set_req(1, 0, 7'h33, 1'b0, 8'h5C);
        push(1, 0, 7'h33, 1'b0, 8'h5C, t + 1, 1'b1, 8'h42, 1'b0, t + 6);
        wait_ready(1, 0, "post_tmo");
        @(posedge clk); #1 drop_req(1, 0);
        wait_until(t + 9);

        // Done with NACK on the expiry cycle: done path wins, data is m_rdata.
        eng_delay[1] = 16; eng_rdata[1] = 8'h5A; eng_nack[1] = 1'b1;
        t = cyc;
        set_req(1, 1, 7'h61, 1'b1, 8'h00);
        push(1, 1, 7'h61, 1'b1, 8'h00, t + 1, 1'b1, 8'h5A, 1'b1, t + 18);
        wait_ready(1, 1, "edge");
        @(posedge clk); #1 drop_req(1, 1);
        wait_until(t + 21);

        // Reset in WAIT: outputs clear at once and no response follows;
        // the engine's late done lands in IDLE and must be ignored.
        eng_delay[0] = 30; eng_rdata[0] = 8'hCC; eng_nack[0] = 1'b0;
        t = cyc;
        set_req(0, 1, 7'h0F, 1'b1, 8'h00);
        push(0, 1, 7'h0F, 1'b1, 8'h00, t + 1, 1'b0, 8'h00, 1'b0, 0);
        wait_ready(0, 1, "abort");
        @(posedge clk); #1 drop_req(0, 1);
        wait_until(t + 6);
        #2 rst_n = 1'b0;
        #1 check_zero(0, "midreset");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        wait_until(t + 34);

        // After reset, requester 0 wins a simultaneous request.
        eng_delay[0] = 2; eng_rdata[0] = 8'hAB; eng_nack[0] = 1'b0;
        t = cyc;
        set_req(0, 0, 7'h11, 1'b0, 8'hEE);
        set_req(0, 1, 7'h12, 1'b1, 8'h00);
        push(0, 0, 7'h11, 1'b0, 8'hEE, t + 1, 1'b1, 8'hAB, 1'b0, t + 4);
        wait_ready(0, 0, "post_rst");
        @(posedge clk); #1 drop_req(0, 0); drop_req(0, 1);
        wait_until(t + 10);

        check("iss_qa_drained", 32'(iss_qa.size()), 32'd0);
        check("rsp_qa_drained", 32'(rsp_qa.size()), 32'd0);
        check("iss_qt_drained", 32'(iss_qt.size()), 32'd0);
        check("rsp_qt_drained", 32'(rsp_qt.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
